// File: rtl/netdma_read_ctrl.sv
// Read-side DMA descriptor controller: issues word requests and tracks returned dataunits.
// Optional statistics counters enabled with `define NETDMA_READ_CTRL_STATS_EN.
module netdma_read_ctrl #(
   parameter int DATA_WIDTH = 64,
   parameter int LEN_WIDTH  = 16,
   localparam int NB        = DATA_WIDTH / 8,
   localparam int OW        = $clog2(NB)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 desc_valid_i,
   output logic                 desc_ready_o,
   input  logic [31:0]          desc_addr_i,
   input  logic [LEN_WIDTH-1:0] desc_len_i,
   input  logic                 new_pending_i,
   input  logic                 new_dataunit_i,
   output logic [31:0]          address_o,
   output logic                 run_posedge_o,
   output logic                 run_requests_o,
   output logic                 run_receive_o,
   output logic                 eop_o,
   output logic [OW-1:0]        empty_o,
   output logic                 done_o,
   output logic                 busy_o
`ifdef NETDMA_READ_CTRL_STATS_EN
   ,
   output logic [31:0]          xfer_cnt_o,
   output logic [31:0]          byte_cnt_o
`endif
);

   localparam int AW = 32 - OW;
   localparam int CW = LEN_WIDTH + 2;  // headroom for offset + length + rounding

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t               state;
   logic [AW-1:0]        word_addr;
   logic [OW-1:0]        off;
   logic [LEN_WIDTH-1:0] len;
   logic [CW-1:0]        reqs_left;
   logic [CW-1:0]        units_left;
   logic                 pend_fire;
   logic                 unit_fire;

   function automatic logic [CW-1:0] ceil_nb(input logic [CW-1:0] nbytes);
      return (nbytes + CW'(NB - 1)) >> OW;
   endfunction

   // Bytes of padding in the final dataunit; NB is a power of two so truncation is the modulo.
   function automatic logic [OW-1:0] tail_empty(input logic [LEN_WIDTH-1:0] nbytes);
      logic [OW-1:0] r;
      r = '0 - nbytes[OW-1:0];
      return r;
   endfunction

   assign desc_ready_o   = (state == IDLE);
   assign busy_o         = (state != IDLE);
   assign run_requests_o = (state == REQ);
   assign run_receive_o  = (state == REQ) || (state == DRAIN);
   assign address_o      = {word_addr, off};
   assign eop_o          = run_receive_o && (units_left == CW'(1));
   assign empty_o        = eop_o ? tail_empty(len) : '0;

   // Zero-count guards keep stray strobes from wrapping the counters.
   assign pend_fire = new_pending_i && run_requests_o && (reqs_left != '0);
   assign unit_fire = new_dataunit_i && run_receive_o && (units_left != '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= IDLE;
         word_addr     <= '0;
         off           <= '0;
         len           <= '0;
         reqs_left     <= '0;
         units_left    <= '0;
         run_posedge_o <= 1'b0;
         done_o        <= 1'b0;
      end else begin
         run_posedge_o <= 1'b0;
         done_o        <= 1'b0;
         case (state)
            IDLE: begin
               if (desc_valid_i) begin
                  word_addr <= desc_addr_i[31:OW];
                  off       <= desc_addr_i[OW-1:0];
                  len       <= desc_len_i;
                  if (desc_len_i != '0) begin
                     reqs_left     <= ceil_nb(CW'(desc_len_i) + CW'(desc_addr_i[OW-1:0]));
                     units_left    <= ceil_nb(CW'(desc_len_i));
                     state         <= REQ;
                     run_posedge_o <= 1'b1;
                  end else begin
                     done_o <= 1'b1;
                  end
               end
            end
            REQ, DRAIN: begin
               if (pend_fire) begin
                  word_addr <= word_addr + 1'b1;
                  reqs_left <= reqs_left - 1'b1;
                  if (reqs_left == CW'(1)) state <= DRAIN;
               end
               // Completion takes priority over the REQ->DRAIN move.
               if (unit_fire) begin
                  units_left <= units_left - 1'b1;
                  if (units_left == CW'(1)) begin
                     state  <= IDLE;
                     done_o <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef NETDMA_READ_CTRL_STATS_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         xfer_cnt_o <= '0;
         byte_cnt_o <= '0;
      end else if (done_o) begin
         xfer_cnt_o <= xfer_cnt_o + 32'd1;
         byte_cnt_o <= byte_cnt_o + 32'(len);
      end
   end
`endif

endmodule

// File: tb/tb_netdma_read_ctrl.sv
// Scoreboard bench for netdma_read_ctrl (DATA_WIDTH 64); checks stats ports when
// NETDMA_READ_CTRL_STATS_EN is defined.
module tb_netdma_read_ctrl;

   localparam int NB = 8;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        desc_valid_i;
   logic        desc_ready_o;
   logic [31:0] desc_addr_i;
   logic [15:0] desc_len_i;
   logic        new_pending_i;
   logic        new_dataunit_i;
   logic [31:0] address_o;
   logic        run_posedge_o;
   logic        run_requests_o;
   logic        run_receive_o;
   logic        eop_o;
   logic [2:0]  empty_o;
   logic        done_o;
   logic        busy_o;
   logic [31:0] xfer_cnt_o;
   logic [31:0] byte_cnt_o;

   netdma_read_ctrl #(.DATA_WIDTH(64), .LEN_WIDTH(16)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .desc_valid_i   (desc_valid_i),
      .desc_ready_o   (desc_ready_o),
      .desc_addr_i    (desc_addr_i),
      .desc_len_i     (desc_len_i),
      .new_pending_i  (new_pending_i),
      .new_dataunit_i (new_dataunit_i),
      .address_o      (address_o),
      .run_posedge_o  (run_posedge_o),
      .run_requests_o (run_requests_o),
      .run_receive_o  (run_receive_o),
      .eop_o          (eop_o),
      .empty_o        (empty_o),
      .done_o         (done_o),
      .busy_o         (busy_o)
`ifdef NETDMA_READ_CTRL_STATS_EN
      ,
      .xfer_cnt_o     (xfer_cnt_o),
      .byte_cnt_o     (byte_cnt_o)
`endif
   );

`ifndef NETDMA_READ_CTRL_STATS_EN
   assign xfer_cnt_o = '0;
   assign byte_cnt_o = '0;
`endif

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic       eop;
      logic [2:0] empty;
   } unit_t;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_addr_q[$];
   unit_t       exp_unit_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] addr, input int len);
      int    off;
      int    nreq;
      int    nunit;
      unit_t u;
      off   = int'(addr % NB);
      nreq  = (off + len + NB - 1) / NB;
      nunit = (len + NB - 1) / NB;
      for (int i = 0; i < nreq; i++) exp_addr_q.push_back(addr + 32'(i * NB));
      for (int i = 0; i < nunit; i++) begin
         u.eop   = (i == nunit - 1);
         u.empty = 3'((nunit * NB - len) % NB);
         exp_unit_q.push_back(u);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_addr"},  address_o,      32'h0);
      chk({tag, "_rpos"},  run_posedge_o,  0);
      chk({tag, "_rreq"},  run_requests_o, 0);
      chk({tag, "_rrcv"},  run_receive_o,  0);
      chk({tag, "_eop"},   eop_o,          0);
      chk({tag, "_empty"}, empty_o,        0);
      chk({tag, "_done"},  done_o,         0);
      chk({tag, "_busy"},  busy_o,         0);
      chk({tag, "_ready"}, desc_ready_o,   1);
`ifdef NETDMA_READ_CTRL_STATS_EN
      chk({tag, "_xfer"},  xfer_cnt_o,     0);
      chk({tag, "_bytes"}, byte_cnt_o,     0);
`endif
   endtask

   // Called at a falling edge; returns at the falling edge after the accepting clock edge.
   task automatic accept(input logic [31:0] addr, input int len);
      desc_addr_i  = addr;
      desc_len_i   = 16'(len);
      desc_valid_i = 1'b1;
      for (int t = 0; t < 300 && !desc_ready_o; t++) @(negedge clk_i);
      chk("accept_ready", desc_ready_o, 1);
      push_exp(addr, len);
      @(posedge clk_i);
      #1 desc_valid_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic run_phase(input int stall_cycles, input int abort_units, input bit hold_next,
                            input logic [31:0] nxt_addr, input int nxt_len);
      int    issued = 0;
      int    issued_before;
      int    delivered = 0;
      int    stall = 0;
      int    n_req;
      int    n_unit;
      bit    done_seen = 0;
      unit_t u;
      n_req  = exp_addr_q.size();
      n_unit = exp_unit_q.size();
      chk("run_posedge", run_posedge_o, 1);
      if (hold_next) begin
         desc_addr_i  = nxt_addr;
         desc_len_i   = 16'(nxt_len);
         desc_valid_i = 1'b1;
      end
      for (int t = 0; t < 400; t++) begin
         new_pending_i  = 1'b0;
         new_dataunit_i = 1'b0;
         if (done_o) begin
            done_seen = 1;
            break;
         end
         if (t > 0) chk("posedge_once", run_posedge_o, 0);
         if (abort_units > 0 && delivered == abort_units) begin
            rst_i = 1'b1;
            #1 check_reset_vals("mid_rst");
            exp_addr_q.delete();
            exp_unit_q.delete();
            @(negedge clk_i);
            rst_i = 1'b0;
            return;
         end
         issued_before = issued;
         if (stall > 0) begin
            stall--;
            chk("stall_rreq", run_requests_o, 1);
            if (exp_addr_q.size() > 0) chk("stall_addr", address_o, exp_addr_q[0]);
         end else if (run_requests_o) begin
            if (exp_addr_q.size() == 0) chk("req_count", issued + 1, n_req);
            else chk("req_addr", address_o, exp_addr_q.pop_front());
            new_pending_i = 1'b1;
            issued++;
            if (issued == 1 && stall_cycles > 0) stall = stall_cycles;
         end
         if (run_receive_o && delivered < issued_before && exp_unit_q.size() > 0) begin
            u = exp_unit_q.pop_front();
            chk("eop", eop_o, u.eop);
            if (u.eop) chk("empty", empty_o, u.empty);
            new_dataunit_i = 1'b1;
            delivered++;
         end
         @(negedge clk_i);
      end
      new_pending_i  = 1'b0;
      new_dataunit_i = 1'b0;
      chk("done_seen", done_seen, 1);
      chk("req_total", issued, n_req);
      chk("unit_total", delivered, n_unit);
      if (hold_next) begin
         chk("b2b_ready", desc_ready_o, 1);
         push_exp(nxt_addr, nxt_len);
         @(posedge clk_i);
         #1 desc_valid_i = 1'b0;
         @(negedge clk_i);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i          = 1'b1;
      desc_valid_i   = 1'b0;
      desc_addr_i    = '0;
      desc_len_i     = '0;
      new_pending_i  = 1'b0;
      new_dataunit_i = 1'b0;
      #1 check_reset_vals("por");
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;

      // Aligned 64-byte transfer
      accept(32'h1000, 64);
      run_phase(0, 0, 0, 0, 0);
      @(negedge clk_i);
      chk("aligned_done_pulse", done_o, 0);

      // Strobes in IDLE must not move the address or start anything
      new_pending_i  = 1'b1;
      new_dataunit_i = 1'b1;
      repeat (3) @(negedge clk_i);
      new_pending_i  = 1'b0;
      new_dataunit_i = 1'b0;
      chk("idle_addr", address_o, 32'h1040);
      chk("idle_busy", busy_o, 0);
      chk("idle_done", done_o, 0);

      // Unaligned transfer: two requests, padding in last dataunit
      accept(32'h1003, 10);
      run_phase(0, 0, 0, 0, 0);
      @(negedge clk_i);

      // Request stall after first request
      accept(32'h1000, 32);
      run_phase(5, 0, 0, 0, 0);
      @(negedge clk_i);

      // Zero-length descriptor
      desc_addr_i  = 32'h5000;
      desc_len_i   = 16'd0;
      desc_valid_i = 1'b1;
      @(posedge clk_i);
      #1 desc_valid_i = 1'b0;
      @(negedge clk_i);
      chk("zero_done", done_o, 1);
      chk("zero_rpos", run_posedge_o, 0);
      chk("zero_rreq", run_requests_o, 0);
      chk("zero_rrcv", run_receive_o, 0);
      @(negedge clk_i);
      chk("zero_done_pulse", done_o, 0);
      chk("zero_busy", busy_o, 0);
      chk("zero_rpos2", run_posedge_o, 0);

      // Reset after 3 of 8 dataunits, then a one-request transfer straight away
      accept(32'h1000, 64);
      run_phase(0, 3, 0, 0, 0);
      accept(32'h2000, 8);
      run_phase(0, 0, 0, 0, 0);
      @(negedge clk_i);

      // Back-to-back descriptors from a clean reset
      rst_i = 1'b1;
      #1 check_reset_vals("rst2");
      @(negedge clk_i);
      rst_i = 1'b0;
      accept(32'h3005, 20);
      run_phase(0, 0, 1, 32'h4000, 16);
      run_phase(0, 0, 0, 0, 0);
      @(negedge clk_i);
      chk("b2b_done_pulse", done_o, 0);
      chk("b2b_busy", busy_o, 0);
`ifdef NETDMA_READ_CTRL_STATS_EN
      chk("stats_xfer", xfer_cnt_o, 2);
      chk("stats_bytes", byte_cnt_o, 36);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/netdma_read_ctrl.md
NETDMA_READ_CTRL -- requirements
Module: netdma_read_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the read-side data width in bits; NB = DATA_WIDTH/8 and OW = log2(NB).
REQ-002 Parameter LEN_WIDTH, default 16, SHALL set the descriptor byte-length width.
REQ-003 clk_i  in  1  clock; all logic SHALL be clocked on the rising edge of clk_i.
REQ-004 rst_i  in  1  reset; SHALL be asynchronous and active-high.
REQ-005 desc_valid_i  in  1  descriptor offered.
REQ-006 desc_ready_o  out  1  descriptor accepted when both are high.
REQ-007 desc_addr_i  in  32  start byte address.
REQ-008 desc_len_i  in  LEN_WIDTH  transfer length in bytes.
REQ-009 new_pending_i  in  1  one read request accepted by memory this cycle.
REQ-010 new_dataunit_i  in  1  one aligned dataunit produced this cycle.
REQ-011 address_o  out  32  current request byte address.
REQ-012 run_posedge_o  out  1  one-cycle transfer-start pulse.
REQ-013 run_requests_o  out  1  request phase active.
REQ-014 run_receive_o  out  1  receive phase active.
REQ-015 eop_o  out  1  current dataunit is last.
REQ-016 empty_o  out  OW  unused bytes in last dataunit.
REQ-017 done_o  out  1  one-cycle completion pulse.
REQ-018 busy_o  out  1  state is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, REQ, DRAIN; desc_ready_o SHALL equal (state==IDLE).
REQ-020 On accept with desc_len_i != 0:
  - latch addr = desc_addr_i, len = desc_len_i, off = desc_addr_i[OW-1:0];
  - load reqs_left = ceil((off+len)/NB) and units_left = ceil(len/NB);
  - go to REQ;
  - assert run_posedge_o for exactly the next cycle.
REQ-021 On accept with desc_len_i == 0 the block SHALL stay in IDLE, pulse done_o on the next cycle, and issue no run_posedge_o or requests.
REQ-022 address_o SHALL be {word_addr, off}: word_addr starts at addr[31:OW] and increments by 1 on each new_pending_i while run_requests_o is high; off is constant for the transfer.
REQ-023 run_requests_o SHALL be high in REQ only; each new_pending_i in REQ SHALL decrement reqs_left.
REQ-024 new_pending_i with reqs_left==1 SHALL move REQ to DRAIN on the next cycle.
REQ-025 run_receive_o SHALL be high in REQ and DRAIN.
REQ-026 Each new_dataunit_i while run_receive_o is high SHALL decrement units_left.
REQ-027 eop_o SHALL be combinational: run_receive_o & (units_left==1).
REQ-028 empty_o SHALL be combinational: (NB*ceil(len/NB) - len) modulo NB, valid whenever eop_o is high.
REQ-029 new_dataunit_i with units_left==1 SHALL, on the next edge:
  - return the FSM to IDLE from REQ or DRAIN;
  - pulse done_o for one cycle.
REQ-030 new_pending_i outside REQ and new_dataunit_i in IDLE SHALL be ignored; counters SHALL never underflow.
REQ-031 new_pending_i and new_dataunit_i in the same cycle SHALL both be applied.
REQ-032 A descriptor offered during REQ/DRAIN SHALL wait; back-to-back accept SHALL be possible on the cycle done_o is high.

Reset
REQ-033 Asserting rst_i at any time, including mid-transfer, SHALL force:
  - IDLE, with all counters cleared;
  - address_o=0, run_posedge_o=0, run_requests_o=0, run_receive_o=0, eop_o=0, empty_o=0, done_o=0, busy_o=0, desc_ready_o=1.
REQ-034 The first cycle after rst_i deasserts SHALL accept a descriptor normally.

Configuration
REQ-035 Macro NETDMA_READ_CTRL_STATS_EN, when defined, SHALL add:
  - xfer_cnt_o (out, 32): increments on each done_o;
  - byte_cnt_o (out, 32): adds len on each done_o;
  - both wrap modulo 2^32 and reset to 0.
REQ-036 Without NETDMA_READ_CTRL_STATS_EN these ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-037 Aligned transfer: addr 0x1000, len 64, DATA_WIDTH 64, new_pending_i tied high
  -> 8 requests at addresses 0x1000..0x1038;
  -> eop_o high with the 8th dataunit, empty_o=0;
  -> done_o pulse.
REQ-038 Unaligned transfer: addr 0x1003, len 10
  -> 2 requests at 0x1003 and 0x100B;
  -> 2 dataunits, eop_o on the 2nd, empty_o=6.
REQ-039 Stall: new_pending_i held low for 5 cycles after the 1st request
  -> address_o and run_requests_o held stable; no extra requests.
REQ-040 Zero length: len 0 -> done_o one cycle later; run_requests_o, run_receive_o and run_posedge_o never high.
REQ-041 Reset mid-transfer: rst_i after 3 of 8 dataunits
  -> all outputs at reset values immediately;
  -> a next descriptor (addr 0x2000, len 8) completes with 1 request.
REQ-042 Back-to-back: second descriptor held valid during the first
  -> accepted on the done_o cycle;
  -> run_posedge_o on the following cycle; with STATS_EN, xfer_cnt_o=2.
